multi_digit_display: RTL

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/display_pkg.sv | 38 +++
 rtl/char_fifo.sv | 70 +++++++
 rtl/multi_digit_display.sv | 114 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types, constants and the hex-to-segment decode for the multiplexed display.
package display_pkg;

  typedef struct packed {
    logic       dp;
    logic       blank;
    logic [1:0] spare;
    logic [3:0] value;
  } disp_char_t;

  localparam logic [7:0] BLANK_CHAR = 8'h40;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Character buffer: power-of-two circular FIFO with registered occupancy count.
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  // Head is read combinationally so a pop tick can shift it into the display that same edge.
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o && !clear_i;
    do_pop   = pop_i && !empty_o && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/multi_digit_display.sv
// Scrolling multiplexed 7-segment display fed from a character FIFO.
// Define DISPLAY_DP_EN to drive dp_o from each character's decimal-point bit.
module multi_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int CHAR_PERIOD = 200,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            clear_i,
  input  logic [7:0]                      char_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
  output logic [6:0]                      seg_o,
  output logic                            dp_o,
  output logic [NUM_DIGITS-1:0]           an_o
);

  localparam int CW = $clog2(CHAR_PERIOD);
  localparam int SW = $clog2(SCAN_PERIOD);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]         char_cnt_q, char_cnt_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  disp_char_t            digit_q [NUM_DIGITS];
  disp_char_t            digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  pop_tick, scan_tick, pop_fire;
  logic                  fifo_full, fifo_empty;
  logic [7:0]            fifo_data;

  char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .push_i  (valid_i),
    .pop_i   (pop_tick),
    .data_i  (char_i),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign ready_o   = ~fifo_full;
  assign pop_tick  = (char_cnt_q == CW'(CHAR_PERIOD-1));
  assign scan_tick = (scan_cnt_q == SW'(SCAN_PERIOD-1));
  assign pop_fire  = pop_tick && !fifo_empty && !clear_i;

  always_comb begin
    char_cnt_d = pop_tick ? '0 : char_cnt_q + CW'(1);
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_tick)
      scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS-1)) ? '0 : scan_idx_q + IW'(1);
    for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
    if (pop_fire) begin
      for (int i = NUM_DIGITS-1; i > 0; i--) digit_d[i] = digit_q[i-1];
      digit_d[0] = disp_char_t'(fifo_data);
    end
    if (clear_i) begin
      char_cnt_d = '0;
      scan_cnt_d = '0;
      scan_idx_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = disp_char_t'(BLANK_CHAR);
    end
  end

  // Output stage decodes the currently indexed digit; it lags the index by one clock.
  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
    seg_d = digit_q[scan_idx_q].blank ? SEG_OFF : hex_to_seg(digit_q[scan_idx_q].value);
`ifdef DISPLAY_DP_EN
    dp_d  = ~digit_q[scan_idx_q].dp | digit_q[scan_idx_q].blank;
`else
    dp_d  = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      char_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= disp_char_t'(BLANK_CHAR);
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      char_cnt_q <= char_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule
